// File: rtl/sha3_ahb_vh_bridge.sv
// sha3_ahb_vh_bridge
//
// AHB-Lite slave to valid-hold (VH) host bridge in front of the SHA3/KMAC
// TL-UL adapter. Writes are posted into a small FIFO and drained to the VH
// side in order. Reads wait until that FIFO is empty, so a read never
// overtakes an earlier write.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   haddr_i .. hsize_i
//                   AHB-Lite slave inputs (address phase and write data phase)
//   hresp_o, hreadyout_o, hrdata_o
//                   AHB-Lite slave response
//   dv_o, hld_i, err_i, write_o, addr_o, wdata_o, wstrb_o, size_o, rdata_i
//                   VH host interface. A request completes in a cycle with
//                   dv_o=1 and hld_i=0.
//   err_intr_o      one-cycle pulse when a posted write completes with an error
//   idle_o          no buffered writes, no read pending, no error response active
module sha3_ahb_vh_bridge #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int WR_BUF_DEPTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AHB_ADDR_WIDTH-1:0]   haddr_i,
    input  logic [AHB_DATA_WIDTH-1:0]   hwdata_i,
    input  logic                        hsel_i,
    input  logic                        hwrite_i,
    input  logic                        hready_i,
    input  logic [1:0]                  htrans_i,
    input  logic [2:0]                  hsize_i,
    output logic                        hresp_o,
    output logic                        hreadyout_o,
    output logic [AHB_DATA_WIDTH-1:0]   hrdata_o,
    output logic                        dv_o,
    input  logic                        hld_i,
    input  logic                        err_i,
    output logic                        write_o,
    output logic [AHB_ADDR_WIDTH-1:0]   addr_o,
    output logic [AHB_DATA_WIDTH-1:0]   wdata_o,
    output logic [AHB_DATA_WIDTH/8-1:0] wstrb_o,
    output logic [2:0]                  size_o,
    input  logic [AHB_DATA_WIDTH-1:0]   rdata_i,
    output logic                        err_intr_o,
    output logic                        idle_o
);

    localparam int SW   = AHB_DATA_WIDTH / 8;
    localparam int PTRW = (WR_BUF_DEPTH > 1) ? $clog2(WR_BUF_DEPTH) : 1;
    localparam int CNTW = $clog2(WR_BUF_DEPTH + 1);

    // ST_WR / ST_RD are the AHB data phases; the two ERR states form the
    // two-cycle ERROR response.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                    state_q, state_d;
    logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SW-1:0]             strb_q, strb_d;
    logic [2:0]                size_q, size_d;
    logic [AHB_DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                      err_intr_q, err_intr_d;
    logic [PTRW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]           count_q, count_d;

    logic [AHB_ADDR_WIDTH-1:0] buf_addr_q [WR_BUF_DEPTH];
    logic [AHB_DATA_WIDTH-1:0] buf_data_q [WR_BUF_DEPTH];
    logic [SW-1:0]             buf_strb_q [WR_BUF_DEPTH];
    logic [2:0]                buf_size_q [WR_BUF_DEPTH];

    logic          accept, buf_empty, buf_full, pop, push, rd_done, ready_int;
    logic          req_illegal;
    logic [SW-1:0] req_strb;
    int            req_bytes, req_off;

    // Wrap-around increment, so any depth works (not only powers of two).
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(WR_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Both NONSEQ and SEQ count as real transfers.
    assign accept    = hsel_i & hready_i & ((htrans_i == 2'b10) | (htrans_i == 2'b11));
    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == CNTW'(WR_BUF_DEPTH));
    assign pop       = !buf_empty && !hld_i;
    // A read is only presented once every earlier write has drained.
    assign rd_done   = (state_q == ST_RD) && buf_empty && !hld_i;
    // A full buffer can still take the write if the head pops this cycle.
    assign push      = (state_q == ST_WR) && (!buf_full || pop);

    // Lane strobes and the legality check for the transfer in its address phase.
    always_comb begin
        req_bytes   = 1 << hsize_i;
        req_off     = int'(haddr_i[$clog2(SW)-1:0]);
        req_illegal = (req_bytes > SW) || ((req_off % req_bytes) != 0);
        req_strb    = '0;
        for (int i = 0; i < SW; i++) begin
            req_strb[i] = (i >= req_off) && (i < req_off + req_bytes);
        end
    end

    // The write data phase waits only while the buffer is full and the
    // head is not leaving.
    always_comb begin
        ready_int = 1'b1;
        case (state_q)
            ST_WR:   ready_int = push;
            ST_RD:   ready_int = 1'b0;
            ST_ERR1: ready_int = 1'b0;
            default: ready_int = 1'b1;
        endcase
    end

    assign hreadyout_o = ready_int;
    assign hresp_o     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
    assign hrdata_o    = hrdata_q;
    assign err_intr_o  = err_intr_q;
    assign idle_o      = buf_empty && ((state_q == ST_IDLE) || (state_q == ST_RD_DONE));

    // The buffer head owns the VH port. A pending read is presented only
    // once the buffer has drained.
    always_comb begin
        dv_o    = 1'b0;
        write_o = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        wstrb_o = '0;
        size_o  = '0;
        if (!buf_empty) begin
            dv_o    = 1'b1;
            write_o = 1'b1;
            addr_o  = buf_addr_q[rd_ptr_q];
            wdata_o = buf_data_q[rd_ptr_q];
            wstrb_o = buf_strb_q[rd_ptr_q];
            size_o  = buf_size_q[rd_ptr_q];
        end else if (state_q == ST_RD) begin
            dv_o    = 1'b1;
            addr_o  = addr_q;
            wstrb_o = strb_q;
            size_o  = size_q;
        end
    end

    // When the current data phase completes, the transfer accepted in the
    // same cycle decides the next data phase. Otherwise the read completion
    // and the error response sequence advance the state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        size_d     = size_q;
        hrdata_d   = hrdata_q;
        err_intr_d = pop && err_i;
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CNTW'(push) - CNTW'(pop);
        if (ready_int) begin
            if (accept) begin
                addr_d = haddr_i;
                strb_d = req_strb;
                size_d = hsize_i;
                if (req_illegal) begin
                    state_d = ST_ERR1;
                end else if (hwrite_i) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_RD: begin
                    if (rd_done) begin
                        hrdata_d = err_i ? '0 : rdata_i;
                        state_d  = err_i ? ST_ERR1 : ST_RD_DONE;
                    end
                end
                ST_ERR1: state_d = ST_ERR2;
                default: state_d = state_q;
            endcase
        end
    end

    // Reset discards all buffered writes and any pending read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            strb_q     <= '0;
            size_q     <= '0;
            hrdata_q   <= '0;
            err_intr_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < WR_BUF_DEPTH; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
                buf_strb_q[i] <= '0;
                buf_size_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            size_q     <= size_d;
            hrdata_q   <= hrdata_d;
            err_intr_q <= err_intr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (push) begin
                buf_addr_q[wr_ptr_q] <= addr_q;
                buf_data_q[wr_ptr_q] <= hwdata_i;
                buf_strb_q[wr_ptr_q] <= strb_q;
                buf_size_q[wr_ptr_q] <= size_q;
            end
        end
    end

endmodule
